// File: rtl/router_pkg.sv
// Shared types and helpers for the N-port router controller.
//   state_e : controller state encoding (9 states, 4 bits)
//   addr_w  : width of a port address for a given port count (minimum 1)
package router_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_DECODE_ADDRESS     = 4'd0,
        ST_LOAD_FIRST_DATA    = 4'd1,
        ST_LOAD_DATA          = 4'd2,
        ST_FIFO_FULL_STATE    = 4'd3,
        ST_LOAD_AFTER_FULL    = 4'd4,
        ST_LOAD_PARITY        = 4'd5,
        ST_CHECK_PARITY_ERROR = 4'd6,
        ST_WAIT_TILL_EMPTY    = 4'd7,
        ST_DROP_PACKET        = 4'd8
    } state_e;

    // Address width for n ports; never below one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fsm_nport_wait_timer.sv
// Bounded wait counter used while the controller waits for an empty FIFO.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : clear the count (held while not waiting)
//   en         : count one waiting cycle
//   expired    : count has reached LIMIT-1 (never asserted when LIMIT==0)
module router_wait_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturating increment so the count can never wrap back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (LIMIT != 0) && (cnt_q < CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        expired = 1'b0;
        if (LIMIT != 0) begin
            expired = (cnt_q == CNT_W'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/router_fsm_nport.sv
// N-port router controller FSM: steers one packet stream to one of
// NUM_PORTS output FIFOs, sequencing header/payload/parity loads, with an
// invalid-address drop path and a bounded wait-for-empty timeout.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   data_in           : header address field, sampled in DECODE_ADDRESS
//   pkt_valid         : packet valid from source
//   parity_done       : parity byte captured
//   low_pkt_valid     : pkt_valid fell while FIFO was full
//   fifo_full         : full flag of the selected FIFO
//   fifo_empty        : per-port empty flags
//   soft_reset        : per-port soft resets
//   detect_add .. rst_int_reg : Moore state strobes to register block/synchroniser
//   busy              : stall request to source
//   port_sel          : one-hot latched destination, 0 when none
//   drop_pkt          : packet being discarded
//   timeout           : one-cycle pulse when the wait timeout fires
module router_fsm_nport
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned ADDR_W       = addr_w(NUM_PORTS),
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 pkt_valid,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] port_sel,
    output logic                 drop_pkt,
    output logic                 timeout
);

    // Per-port flags padded to the full address space so any address indexes safely.
    localparam int unsigned SEL_W = 1 << ADDR_W;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;

    logic [SEL_W-1:0]    empty_ext;
    logic [SEL_W-1:0]    soft_ext;
    logic                addr_ok;
    logic                sel_empty;
    logic                sel_soft;
    logic                soft_abort;
    logic                waiting;
    logic                wait_expired;

    assign empty_ext = SEL_W'(fifo_empty);
    assign soft_ext  = SEL_W'(soft_reset);
    assign addr_ok   = (32'(data_in) < NUM_PORTS);
    assign sel_empty = empty_ext[addr_q];
    assign sel_soft  = soft_ext[addr_q];
    assign waiting   = (state_q == ST_WAIT_TILL_EMPTY);

    // Soft reset only matters once a valid port has been latched.
    assign soft_abort = sel_soft
                        && (state_q != ST_DECODE_ADDRESS)
                        && (state_q != ST_DROP_PACKET);

    router_wait_timer #(
        .LIMIT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!waiting),
        .en      (waiting),
        .expired (wait_expired)
    );

    // State and latched-address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    addr_d = data_in;
                    if (!addr_ok) begin
                        state_d = ST_DROP_PACKET;
                    end else if (empty_ext[data_in]) begin
                        state_d = ST_LOAD_FIRST_DATA;
                    end else begin
                        state_d = ST_WAIT_TILL_EMPTY;
                    end
                end
            end
            ST_LOAD_FIRST_DATA: state_d = ST_LOAD_DATA;
            ST_LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = ST_FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end
            end
            ST_FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = ST_LOAD_AFTER_FULL;
                end
            end
            ST_LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = ST_DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = ST_LOAD_PARITY;
                end else begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_PARITY: state_d = ST_CHECK_PARITY_ERROR;
            ST_CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? ST_FIFO_FULL_STATE : ST_DECODE_ADDRESS;
            end
            ST_WAIT_TILL_EMPTY: begin
                // Empty wins over a timeout landing in the same cycle.
                if (sel_empty) begin
                    state_d = ST_LOAD_FIRST_DATA;
                end else if (wait_expired) begin
                    state_d = ST_DROP_PACKET;
                end
            end
            ST_DROP_PACKET: begin
                if (!pkt_valid) begin
                    state_d = ST_DECODE_ADDRESS;
                end
            end
            default: state_d = ST_DECODE_ADDRESS;
        endcase
        if (soft_abort) begin
            state_d = ST_DECODE_ADDRESS;
        end
    end

    // Output decode.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;
        drop_pkt      = 1'b0;
        port_sel      = '0;
        timeout       = 1'b0;
        unique case (state_q)
            ST_DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            ST_LOAD_FIRST_DATA: lfd_state = 1'b1;
            ST_LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            ST_FIFO_FULL_STATE: full_state = 1'b1;
            ST_LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_LOAD_PARITY: write_enb_reg = 1'b1;
            ST_CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            ST_WAIT_TILL_EMPTY: begin
                // Pulse only when the drop transition is actually taken.
                timeout = wait_expired && !sel_empty && !sel_soft;
            end
            ST_DROP_PACKET: begin
                drop_pkt = 1'b1;
                busy     = 1'b0;
            end
            default: busy = 1'b1;
        endcase
        if ((state_q != ST_DECODE_ADDRESS) && (state_q != ST_DROP_PACKET)) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                port_sel[i] = (32'(addr_q) == i);
            end
        end
    end

endmodule

// File: tb/tb_router_fsm_nport.sv
// Self-checking bench for router_fsm_nport (3 ports, 4-cycle wait timeout).
module tb_router_fsm_nport;

    localparam int NP = 3;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] data_in;
    logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
    logic [2:0] fifo_empty, soft_reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy, drop_pkt, timeout;
    logic [2:0] port_sel;

    router_fsm_nport #(
        .NUM_PORTS    (NP),
        .WAIT_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .pkt_valid     (pkt_valid),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .port_sel      (port_sel),
        .drop_pkt      (drop_pkt),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    // Bit order: 12 detect,11 lfd,10 ld,9 laf,8 full,7 wen,6 rst_int,5 busy,4 drop,3 timeout,2:0 port_sel
    logic [12:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
                  rst_int_reg, busy, drop_pkt, timeout, port_sel};

    int total = 0;
    int bad   = 0;

    // Reference model: packet phase, latched port, cycles spent waiting.
    typedef enum int {P_IDLE, P_FIRST, P_BODY, P_STALL, P_RESUME, P_PAR, P_CHK, P_WAIT, P_DROP} ph_e;
    ph_e m_ph;
    int  m_addr;
    int  m_wait;

    function automatic logic m_sel_soft();
        if (m_ph == P_IDLE || m_ph == P_DROP || m_addr >= NP) return 1'b0;
        return soft_reset[m_addr];
    endfunction

    function automatic logic m_fires();
        return (m_ph == P_WAIT) && !fifo_empty[m_addr] && (m_wait == TO - 1) && !m_sel_soft();
    endfunction

    function automatic logic [12:0] model_out();
        logic [12:0] v;
        v = '0;
        v[5] = 1'b1;
        case (m_ph)
            P_IDLE:   begin v[12] = 1'b1; v[5] = 1'b0; end
            P_FIRST:  v[11] = 1'b1;
            P_BODY:   begin v[10] = 1'b1; v[7] = 1'b1; v[5] = 1'b0; end
            P_STALL:  v[8] = 1'b1;
            P_RESUME: begin v[9] = 1'b1; v[7] = 1'b1; end
            P_PAR:    v[7] = 1'b1;
            P_CHK:    v[6] = 1'b1;
            P_WAIT:   v[3] = m_fires();
            P_DROP:   begin v[4] = 1'b1; v[5] = 1'b0; end
            default:  v = 'x;
        endcase
        if (m_ph != P_IDLE && m_ph != P_DROP) v[m_addr] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_addr = 0; m_wait = 0;
    endtask

    task automatic model_advance();
        ph_e n;
        int  na;
        n  = m_ph;
        na = m_addr;
        case (m_ph)
            P_IDLE: if (pkt_valid) begin
                na = int'(data_in);
                if (na >= NP)             n = P_DROP;
                else if (fifo_empty[na])  n = P_FIRST;
                else                      n = P_WAIT;
            end
            P_FIRST:  n = P_BODY;
            P_BODY:   n = fifo_full ? P_STALL : (!pkt_valid ? P_PAR : P_BODY);
            P_STALL:  n = fifo_full ? P_STALL : P_RESUME;
            P_RESUME: n = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
            P_PAR:    n = P_CHK;
            P_CHK:    n = fifo_full ? P_STALL : P_IDLE;
            P_WAIT:   n = fifo_empty[m_addr] ? P_FIRST : ((m_wait == TO - 1) ? P_DROP : P_WAIT);
            P_DROP:   n = pkt_valid ? P_DROP : P_IDLE;
            default:  n = P_IDLE;
        endcase
        if (m_sel_soft()) n = P_IDLE;
        m_wait = (m_ph == P_WAIT && n == P_WAIT) ? m_wait + 1 : 0;
        m_ph   = n;
        m_addr = na;
    endtask

    // Advance model and DUT by one clock; returns at the next falling edge.
    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        data_in = 2'd0; pkt_valid = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        total++;
        if (obs !== 13'b1_0000_0000_0000) begin
            bad++; $display("FAIL reset_hold got=%b want=%b", obs, 13'b1_0000_0000_0000);
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs !== model_out()) begin
            bad++; $display("FAIL reset_release got=%b want=%b", obs, model_out());
        end
        tick();
    endtask

    task automatic test_basic_packet();
        idle_inputs();
        data_in = 2'd1; fifo_empty = 3'b010;
        for (int c = 0; c < 8; c++) begin
            pkt_valid = (c < 4);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL basic cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            if (c == 2) begin
                total++;
                if ({ld_state, write_enb_reg, port_sel} !== 5'b11_010) begin
                    bad++; $display("FAIL basic_ld got=%b want=%b", {ld_state, write_enb_reg, port_sel}, 5'b11_010);
                end
            end
            if (c == 6) begin
                total++;
                if (rst_int_reg !== 1'b1) begin
                    bad++; $display("FAIL basic_cpe got=%b want=1", rst_int_reg);
                end
            end
            tick();
        end
    endtask

    task automatic test_fifo_full();
        idle_inputs();
        data_in = 2'd1; fifo_empty = 3'b010;
        for (int c = 0; c < 9; c++) begin
            pkt_valid     = (c < 5);
            fifo_full     = (c == 2 || c == 3);
            low_pkt_valid = (c == 5);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL full cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            if (c == 3 || c == 4) begin
                total++;
                if ({full_state, busy} !== 2'b11) begin
                    bad++; $display("FAIL full_busy cyc=%0d got=%b want=11", c, {full_state, busy});
                end
            end
            if (c == 5) begin
                total++;
                if (laf_state !== 1'b1) begin
                    bad++; $display("FAIL full_laf got=%b want=1", laf_state);
                end
            end
            tick();
        end
    endtask

    task automatic test_drop();
        idle_inputs();
        data_in = 2'd3;
        for (int c = 0; c < 5; c++) begin
            pkt_valid = (c < 3);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL drop cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            if (c == 1) begin
                total++;
                if ({drop_pkt, busy, write_enb_reg, port_sel} !== 6'b100_000) begin
                    bad++; $display("FAIL drop_out got=%b want=100000", {drop_pkt, busy, write_enb_reg, port_sel});
                end
            end
            if (c == 4) begin
                total++;
                if (detect_add !== 1'b1) begin
                    bad++; $display("FAIL drop_exit got=%b want=1", detect_add);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int pulses;
        for (int rep = 0; rep < 2; rep++) begin
            idle_inputs();
            data_in = 2'd2; fifo_empty = 3'b011;
            pulses = 0;
            for (int c = 0; c < 10; c++) begin
                pkt_valid = (c < 6);
                if (rep == 1 && c >= 4) fifo_empty = 3'b111;
                #1;
                total++;
                if (obs !== model_out()) begin
                    bad++; $display("FAIL wait rep=%0d cyc=%0d got=%b want=%b", rep, c, obs, model_out());
                end
                if (timeout === 1'b1) pulses++;
                if (c == 5) begin
                    total++;
                    if ({drop_pkt, lfd_state} !== ((rep == 0) ? 2'b10 : 2'b01)) begin
                        bad++; $display("FAIL wait_exit rep=%0d got=%b want=%b", rep, {drop_pkt, lfd_state},
                                        (rep == 0) ? 2'b10 : 2'b01);
                    end
                end
                tick();
            end
            total++;
            if (pulses != ((rep == 0) ? 1 : 0)) begin
                bad++; $display("FAIL wait_pulses rep=%0d got=%0d want=%0d", rep, pulses, (rep == 0) ? 1 : 0);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_soft_reset();
        idle_inputs();
        data_in = 2'd1; fifo_empty = 3'b010;
        for (int c = 0; c < 6; c++) begin
            pkt_valid  = (c < 4);
            soft_reset = (c == 2) ? 3'b001 : ((c == 3) ? 3'b010 : 3'b000);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL soft cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            if (c == 3) begin
                total++;
                if (ld_state !== 1'b1) begin
                    bad++; $display("FAIL soft_other got=%b want=1", ld_state);
                end
            end
            if (c == 4) begin
                total++;
                if (detect_add !== 1'b1) begin
                    bad++; $display("FAIL soft_sel got=%b want=1", detect_add);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        data_in = 2'd0; fifo_empty = 3'b001; pkt_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            fifo_full = (c >= 2);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL arst cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            if (c < 3) tick();
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({detect_add, full_state, port_sel} !== 5'b10_000) begin
            bad++; $display("FAIL arst_now got=%b want=10000", {detect_add, full_state, port_sel});
        end
        model_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== model_out()) begin
            bad++; $display("FAIL arst_after got=%b want=%b", obs, model_out());
        end
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) pkt_valid = ~pkt_valid;
            data_in       = 2'($urandom_range(0, 3));
            fifo_empty    = 3'($urandom_range(0, 7));
            fifo_full     = ($urandom_range(0, 4) == 0);
            parity_done   = ($urandom_range(0, 4) == 0);
            low_pkt_valid = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NP; p++) soft_reset[p] = ($urandom_range(0, 24) == 0);
            #1;
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL random cyc=%0d got=%b want=%b", c, obs, model_out());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_fifo_full();
        test_drop();
        test_timeout();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
